// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM states, action encoding and stage-control bundle for the pipeline sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} ctrl_state_e;

  typedef enum logic [2:0] {ACT_FREEZE, ACT_SQUASH, ACT_LDSTALL, ACT_FSTALL, ACT_NORMAL} action_e;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_target;
    logic ifdc_en;
    logic ifdc_flush;
    logic dcex_en;
    logic dcex_flush;
    logic exwb_en;
  } stage_ctrl_t;

  function automatic stage_ctrl_t act_ctrl(action_e a);
    stage_ctrl_t s;
    s.pc_en         = a inside {ACT_SQUASH, ACT_NORMAL};
    s.pc_sel_target = a == ACT_SQUASH;
    s.ifdc_en       = a inside {ACT_SQUASH, ACT_FSTALL, ACT_NORMAL};
    s.ifdc_flush    = a inside {ACT_SQUASH, ACT_FSTALL};
    s.dcex_en       = a != ACT_FREEZE;
    s.dcex_flush    = a inside {ACT_SQUASH, ACT_LDSTALL};
    s.exwb_en       = a != ACT_FREEZE;
    return s;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + 1'b1;

  assign count = r_count;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: turns stall/squash/memory-wait requests into per-stage enables and flushes,
// with a data-memory timeout FSM and saturating stall/squash counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_stall,
  input  logic             branch_taken,
  input  logic             imem_valid,
  input  logic             dmem_req,
  input  logic             dmem_valid,
  output logic             pc_en,
  output logic             pc_sel_target,
  output logic             ifdc_en,
  output logic             ifdc_flush,
  output logic             dcex_en,
  output logic             dcex_flush,
  output logic             exwb_en,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] squash_count
);
  localparam int WW = $clog2(MEM_TIMEOUT);

  ctrl_state_e r_state, w_next;
  logic [WW-1:0] r_wait;
  logic r_mem_error;
  logic w_freeze;
  action_e w_act;
  stage_ctrl_t w_ctrl;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= RUN;
      r_wait      <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wait      <= r_state == MEM_WAIT ? r_wait + 1'b1 : '0;
      r_mem_error <= r_mem_error | (w_next == HALT);
    end

  // HALT reuses the freeze action so it gets zero controls and counts as a stall.
  always_comb begin
    w_freeze = (r_state == MEM_WAIT && !dmem_valid) || (r_state == RUN && dmem_req && !dmem_valid);
    w_act    = (r_state == HALT || w_freeze) ? ACT_FREEZE :
               branch_taken ? ACT_SQUASH :
               load_stall   ? ACT_LDSTALL :
               !imem_valid  ? ACT_FSTALL : ACT_NORMAL;
    w_ctrl   = rst ? '0 : act_ctrl(w_act);
    w_next   = r_state;
    if (r_state == RUN && dmem_req && !dmem_valid) w_next = MEM_WAIT;
    else if (r_state == MEM_WAIT) w_next = dmem_valid ? RUN : r_wait == WW'(MEM_TIMEOUT - 1) ? HALT : MEM_WAIT;
  end

  assign pc_en         = w_ctrl.pc_en;
  assign pc_sel_target = w_ctrl.pc_sel_target;
  assign ifdc_en       = w_ctrl.ifdc_en;
  assign ifdc_flush    = w_ctrl.ifdc_flush;
  assign dcex_en       = w_ctrl.dcex_en;
  assign dcex_flush    = w_ctrl.dcex_flush;
  assign exwb_en       = w_ctrl.exwb_en;
  assign mem_error     = r_mem_error;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_act inside {ACT_FREEZE, ACT_LDSTALL, ACT_FSTALL}),
    .count(stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_act == ACT_SQUASH),
    .count(squash_count)
  );
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the VLIW core. Collects the stall and squash requests (load-use stall from hazard detection, taken-branch squash, data-memory wait, instruction-fetch wait) and converts them into per-stage register enables, bubble-insert (flush) controls and a PC-select. It also tracks outstanding data-memory accesses with a timeout FSM and keeps saturating performance counters. It sits between the hazard detection unit, the LSU/memory handshake and the pipeline registers of all three issue pipes (IXU1, IXU2, LSU).

## Interface
Parameters:
- MEM_TIMEOUT, 64: max cycles in MEM_WAIT before the error halt (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_stall  in  1  load-use RAW stall request from hazard detection.
- branch_taken  in  1  a taken branch resolved in EX.
- imem_valid  in  1  fetch bundle available this cycle.
- dmem_req  in  1  the LSU EX op is a load/store awaiting memory.
- dmem_valid  in  1  memory completes the outstanding access this cycle.
- pc_en  out  1  PC register update enable.
- pc_sel_target  out  1  PC loads the branch target instead of PC+bundle.
- ifdc_en / ifdc_flush  out  1 each  IF/DC register enable, load NOP bundle.
- dcex_en / dcex_flush  out  1 each  DC/EX register enable, load NOP bundle (all 3 pipes).
- exwb_en  out  1  EX/WB register enable.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  cycles with any stall or freeze.
- squash_count  out  CNT_W  taken-branch squashes.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state RUN.
- A flush register loads a NOP bundle when its en=1 and flush=1.
- Actions are evaluated each cycle in priority order. All outputs are combinational from state and inputs.
  - Freeze: state MEM_WAIT without dmem_valid, or RUN with dmem_req=1 and dmem_valid=0. All enables are 0 and all flushes are 0.
  - Squash: branch_taken=1. pc_en=1, pc_sel_target=1, ifdc_en=ifdc_flush=1, dcex_en=dcex_flush=1, exwb_en=1.
  - Load stall: pc_en=0, ifdc_en=0, dcex_en=dcex_flush=1, exwb_en=1.
  - Fetch stall: imem_valid=0. pc_en=0, ifdc_en=ifdc_flush=1, dcex_en=exwb_en=1.
  - Normal: all enables 1, flushes 0, pc_sel_target=0.
- Transitions:
  - RUN→MEM_WAIT on dmem_req & !dmem_valid.
  - MEM_WAIT→RUN on dmem_valid.
  - MEM_WAIT→HALT when the wait counter reaches MEM_TIMEOUT-1 without dmem_valid.
  - HALT is terminal until rst.
- MEM_WAIT release cycle (dmem_valid=1): the freeze lifts in that same cycle. The remaining priorities apply normally, so a branch_taken held in the frozen EX squashes on the release cycle.
- HALT: all enables 0, flushes 0, mem_error=1.
- Wait counter: cleared on entry to MEM_WAIT and counts cycles spent in MEM_WAIT; ceil(log2(MEM_TIMEOUT)) bits.
- Counters saturate at all-ones:
  - stall_cycles increments on freeze, load stall, fetch stall and every HALT cycle.
  - squash_count increments on each squash cycle.

## Timing
- Control outputs have zero latency (combinational). State, wait counter, mem_error and the perf counters update on the clock edge.
- Reset (asynchronous, mid-operation included): state=RUN, wait counter=0, mem_error=0, both perf counters=0. While rst=1, every enable, flush and pc_sel_target is forced to 0.
- Zero-wait memory (dmem_req & dmem_valid in the same cycle): no freeze, no state change.
- N-wait access: exactly N freeze cycles, then release on the cycle dmem_valid rises.
- Simultaneous events:
  - Freeze beats squash, load stall and fetch stall.
  - Squash beats load stall and fetch stall.
  - Load stall beats fetch stall.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the ctrl_state_e enum (RUN, MEM_WAIT, HALT);
  - the action enum (ACT_FREEZE, ACT_SQUASH, ACT_LDSTALL, ACT_FSTALL, ACT_NORMAL);
  - a stage_ctrl_t packed struct bundling pc_en, pc_sel_target, ifdc_en/flush, dcex_en/flush and exwb_en.
- One sub-module, sat_counter (parameter W, inputs inc and rst, saturating), instantiated twice.

## Test plan
- Reset, then all inputs idle with imem_valid=1: every enable 1, flushes 0, counters stay 0. Assert rst mid-run: enables drop to 0 immediately and the counters clear.
- load_stall=1 for 1 cycle: pc_en=0, ifdc_en=0, dcex_flush=1, exwb_en=1; stall_cycles=1.
- branch_taken=1 together with load_stall=1: squash outputs only (pc_sel_target=1, ifdc_flush=dcex_flush=1); squash_count=1, stall_cycles=0.
- dmem_req=1 with dmem_valid arriving after 3 cycles: 3 freeze cycles, release on the 4th cycle, stall_cycles=3. Hold branch_taken=1 throughout: the squash fires only on the release cycle.
- MEM_TIMEOUT=8, dmem_req=1, dmem_valid never: after 8 MEM_WAIT cycles state=HALT, mem_error=1 sticky, enables 0; rst returns the block to RUN.
- CNT_W=4, 20 consecutive fetch stalls: stall_cycles saturates at 15.
